// File: rtl/pu_or1k_pkg.sv
// Types and constants shared by the PIC interrupt scheduler and its priority encoder.
`ifndef OR1K_SPR_PICSR_ADDR
`define OR1K_SPR_PICSR_ADDR 16'h4802
`endif

package pu_or1k_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    SERVICE = 3'd2,
    CLEAR   = 3'd3,
    HOLDOFF = 3'd4
  } pic_sched_state_t;

  localparam logic [15:0] SPR_PICSR_ADDR = `OR1K_SPR_PICSR_ADDR;

endpackage

// File: rtl/pu_or1k_defines.sv
// Shared OR1K SPR address macros for the PU blocks.
`ifndef OR1K_SPR_PICSR_ADDR
`define OR1K_SPR_PICSR_ADDR 16'h4802
`endif

// File: rtl/pu_or1k_pic_prio_enc.sv
// Rotating 32-line priority encoder: the first set bit at or after base wins, wrapping mod 32.
module pu_or1k_pic_prio_enc (
  input  logic [31:0] req,
  input  logic [4:0]  base,
  output logic        valid,
  output logic [4:0]  idx
);

  logic [63:0] w_dbl;
  logic [31:0] w_rot;
  logic [4:0]  w_off;

  // Rotate right by base so the search always starts at bit 0 of w_rot.
  assign w_dbl = {req, req} >> base;
  assign w_rot = w_dbl[31:0];

  always_comb begin
    w_off = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (w_rot[i]) w_off = 5'(i);
    end
  end

  assign valid = |req;
  assign idx   = base + w_off;

endmodule

// File: rtl/pu_or1k_pic_sched.sv
// Interrupt scheduler: picks a pending PICSR line, holds the request, tracks service to EOI,
// clears the PICSR bit over SPR (non-LEVEL modes) and enforces a re-arm gap.
module pu_or1k_pic_sched
  import pu_or1k_pkg::*;
#(
  parameter string OPTION_PIC_TRIGGER = "LEVEL",
  parameter int    OPTION_RR          = 0,
  parameter int    HOLDOFF_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      picsr_i,
  input  logic             iee_i,
  output logic             irq_req_o,
  output logic [4:0]       irq_vec_o,
  input  logic             irq_ack_i,
  input  logic             eoi_i,
  output logic             busy_o,
  output logic             spr_req_o,
  output logic [15:0]      spr_addr_o,
  output logic [31:0]      spr_dat_o,
  input  logic             spr_ack_i,
  output pic_sched_state_t dbg_state_o
);

  localparam bit         LP_LEVEL = (OPTION_PIC_TRIGGER == "LEVEL");
  localparam logic [3:0] LP_HOLD  = 4'(HOLDOFF_CYCLES);

  pic_sched_state_t r_state;
  pic_sched_state_t w_next;
  logic [4:0]       r_vec;
  logic [4:0]       r_last;
  logic             r_seen;
  logic [3:0]       r_cnt;
  logic [4:0]       w_base;
  logic             w_valid;
  logic [4:0]       w_idx;

  // Until the first completed service there is no "last" line, so the search starts at 0.
  assign w_base = (OPTION_RR != 0 && r_seen) ? r_last + 5'd1 : 5'd0;

  pu_or1k_pic_prio_enc u_enc (
    .req   (picsr_i),
    .base  (w_base),
    .valid (w_valid),
    .idx   (w_idx)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (iee_i && w_valid) w_next = REQ;
      REQ: begin
        if (irq_ack_i)                      w_next = SERVICE;
        else if (!picsr_i[r_vec] || !iee_i) w_next = IDLE;
      end
      SERVICE: if (eoi_i) w_next = LP_LEVEL ? HOLDOFF : CLEAR;
      CLEAR:   if (spr_ack_i) w_next = HOLDOFF;
      HOLDOFF: if (r_cnt == 4'd0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= 5'd0;
      r_last  <= 5'd0;
      r_seen  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == REQ) r_vec <= w_idx;
      if (w_next == HOLDOFF && r_state != HOLDOFF) begin
        r_cnt  <= LP_HOLD;
        r_last <= r_vec;
        r_seen <= 1'b1;
      end else if (r_state == HOLDOFF && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign irq_req_o   = (r_state == REQ);
  assign irq_vec_o   = r_vec;
  assign busy_o      = (r_state != IDLE);
  assign spr_req_o   = (r_state == CLEAR);
  assign spr_addr_o  = spr_req_o ? SPR_PICSR_ADDR : 16'h0;
  assign spr_dat_o   = spr_req_o ? (32'd1 << r_vec) : 32'd0;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pu_or1k_pic_sched.sv
// Bench for pu_or1k_pic_sched: three configurations share stimulus and are checked every cycle
// against a behavioural scheduler model, plus directed scenarios with literal expectations.
module tb_pu_or1k_pic_sched;

  localparam int NI = 3;
  localparam logic [15:0] PICSR_ADDR = 16'h4802;

  logic        clk;
  logic        rst_n;
  logic [31:0] picsr;
  logic        iee, ack, eoi, spr_ack;

  logic        req_w  [NI];
  logic [4:0]  vec_w  [NI];
  logic        busy_w [NI];
  logic        sreq_w [NI];
  logic [15:0] addr_w [NI];
  logic [31:0] dat_w  [NI];
  logic [2:0]  st_w   [NI];

  int n_total = 0;
  int n_bad   = 0;
  int n_print = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instance 0: EDGE, fixed priority, holdoff 2
  pu_or1k_pic_sched #(.OPTION_PIC_TRIGGER("EDGE"), .OPTION_RR(0), .HOLDOFF_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .picsr_i(picsr), .iee_i(iee),
    .irq_req_o(req_w[0]), .irq_vec_o(vec_w[0]), .irq_ack_i(ack), .eoi_i(eoi),
    .busy_o(busy_w[0]), .spr_req_o(sreq_w[0]), .spr_addr_o(addr_w[0]), .spr_dat_o(dat_w[0]),
    .spr_ack_i(spr_ack), .dbg_state_o(st_w[0]));

  // Instance 1: LEVEL, round-robin, holdoff 0
  pu_or1k_pic_sched #(.OPTION_PIC_TRIGGER("LEVEL"), .OPTION_RR(1), .HOLDOFF_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .picsr_i(picsr), .iee_i(iee),
    .irq_req_o(req_w[1]), .irq_vec_o(vec_w[1]), .irq_ack_i(ack), .eoi_i(eoi),
    .busy_o(busy_w[1]), .spr_req_o(sreq_w[1]), .spr_addr_o(addr_w[1]), .spr_dat_o(dat_w[1]),
    .spr_ack_i(spr_ack), .dbg_state_o(st_w[1]));

  // Instance 2: LATCHED_LEVEL, round-robin, holdoff 5
  pu_or1k_pic_sched #(.OPTION_PIC_TRIGGER("LATCHED_LEVEL"), .OPTION_RR(1), .HOLDOFF_CYCLES(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .picsr_i(picsr), .iee_i(iee),
    .irq_req_o(req_w[2]), .irq_vec_o(vec_w[2]), .irq_ack_i(ack), .eoi_i(eoi),
    .busy_o(busy_w[2]), .spr_req_o(sreq_w[2]), .spr_addr_o(addr_w[2]), .spr_dat_o(dat_w[2]),
    .spr_ack_i(spr_ack), .dbg_state_o(st_w[2]));

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 requesting, 2 in service, 3 clearing PICSR bit, 4 re-arm gap.
  int m_ph   [NI] = '{default: 0};
  int m_vec  [NI] = '{default: 0};
  int m_last [NI] = '{default: 0};
  int m_seen [NI] = '{default: 0};
  int m_gap  [NI] = '{default: 0};

  function automatic bit cfg_level(int i); return (i == 1); endfunction
  function automatic bit cfg_rr(int i);    return (i != 0); endfunction
  function automatic int cfg_hold(int i);
    case (i)
      0: return 2;
      1: return 0;
      default: return 5;
    endcase
  endfunction

  function automatic int pick(logic [31:0] p, int base);
    for (int k = 0; k < 32; k++) begin
      if (p[(base + k) % 32]) return (base + k) % 32;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_ph[i] <= 0; m_vec[i] <= 0; m_last[i] <= 0; m_seen[i] <= 0; m_gap[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        case (m_ph[i])
          0: if (iee && picsr != 0) begin
            m_vec[i] <= pick(picsr, (cfg_rr(i) && m_seen[i] != 0) ? (m_last[i] + 1) % 32 : 0);
            m_ph[i]  <= 1;
          end
          1: if (ack) m_ph[i] <= 2;
             else if (!picsr[m_vec[i]] || !iee) m_ph[i] <= 0;
          2: if (eoi) begin
            if (cfg_level(i)) begin
              m_ph[i] <= 4; m_gap[i] <= cfg_hold(i); m_last[i] <= m_vec[i]; m_seen[i] <= 1;
            end else begin
              m_ph[i] <= 3;
            end
          end
          3: if (spr_ack) begin
            m_ph[i] <= 4; m_gap[i] <= cfg_hold(i); m_last[i] <= m_vec[i]; m_seen[i] <= 1;
          end
          default: if (m_gap[i] == 0) m_ph[i] <= 0;
                   else m_gap[i] <= m_gap[i] - 1;
        endcase
      end
    end
  end

  function automatic logic [55:0] model_out(int i);
    logic r, s;
    r = (m_ph[i] == 1);
    s = (m_ph[i] == 3);
    return {r, 5'(m_vec[i]), (m_ph[i] != 0), s, (s ? PICSR_ADDR : 16'h0),
            (s ? (32'd1 << m_vec[i]) : 32'd0)};
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      n_total++;
      if ({req_w[i], vec_w[i], busy_w[i], sreq_w[i], addr_w[i], dat_w[i]} !== model_out(i)) begin
        n_bad++;
        if (n_print < 30) begin
          n_print++;
          $display("FAIL cycle_cmp inst=%0d t=%0t act={req,vec,busy,sreq,addr,dat}=%h exp=%h",
                   i, $time, {req_w[i], vec_w[i], busy_w[i], sreq_w[i], addr_w[i], dat_w[i]},
                   model_out(i));
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; picsr = 32'h0; iee = 1'b0; ack = 1'b0; eoi = 1'b0; spr_ack = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_ack();  ack = 1'b1;     step(); ack = 1'b0;     endtask
  task automatic pulse_eoi();  eoi = 1'b1;     step(); eoi = 1'b0;     endtask

  task automatic wait_req(input int inst, output int cyc);
    cyc = 0;
    while (!req_w[inst] && cyc < 30) begin
      step();
      cyc++;
    end
    chk("wait_req", 64'(req_w[inst]), 64'd1);
  endtask

  int cyc;
  int exp_seq [4] = '{0, 31, 0, 31};

  initial begin
    do_reset();
    rst_n = 1'b0;
    step();
    for (int i = 0; i < NI; i++) begin
      chk("reset_state", {8'h0, req_w[i], vec_w[i], busy_w[i], sreq_w[i], addr_w[i], dat_w[i]}, 64'h0);
    end
    rst_n = 1'b1;

    // 1: EDGE fixed priority, full service with PICSR clear then next line
    picsr = 32'h0000_0014; iee = 1'b1;
    step();
    chk("t1_req", 64'(req_w[0]), 64'd1);
    chk("t1_vec", 64'(vec_w[0]), 64'd2);
    pulse_ack();
    chk("t1_service_req_low", 64'(req_w[0]), 64'd0);
    chk("t1_service_busy", 64'(busy_w[0]), 64'd1);
    pulse_eoi();
    chk("t1_spr_req", 64'(sreq_w[0]), 64'd1);
    chk("t1_spr_dat", 64'(dat_w[0]), 64'h4);
    chk("t1_spr_addr", 64'(addr_w[0]), 64'(PICSR_ADDR));
    step();
    chk("t1_spr_dat_stable", 64'(dat_w[0]), 64'h4);
    spr_ack = 1'b1; picsr = 32'h0000_0010;
    step();
    spr_ack = 1'b0;
    chk("t1_holdoff_busy", 64'(busy_w[0]), 64'd1);
    chk("t1_holdoff_sreq", 64'(sreq_w[0]), 64'd0);
    wait_req(0, cyc);
    chk("t1_gap_ge2", 64'(cyc >= 2), 64'd1);
    chk("t1_vec2", 64'(vec_w[0]), 64'd4);

    // 2: LEVEL round-robin alternates between lines 0 and 31
    do_reset();
    picsr = 32'h8000_0001; iee = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(1, cyc);
      chk("t2_rr_vec", 64'(vec_w[1]), 64'(exp_seq[k]));
      pulse_ack();
      pulse_eoi();
      chk("t2_level_no_spr", 64'(sreq_w[1]), 64'd0);
    end

    // 3: withdrawal, then ack in the drop cycle
    do_reset();
    picsr = 32'h0000_0020; iee = 1'b1;
    step();
    chk("t3_req", 64'(req_w[0]), 64'd1);
    chk("t3_vec", 64'(vec_w[0]), 64'd5);
    picsr = 32'h0;
    step();
    chk("t3_withdraw_req", 64'(req_w[0]), 64'd0);
    chk("t3_withdraw_idle", 64'(busy_w[0]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_no_spr", 64'(sreq_w[0]), 64'd0);
    end
    picsr = 32'h0000_0020;
    step();
    chk("t3_req_again", 64'(req_w[0]), 64'd1);
    picsr = 32'h0; ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_ack_wins_busy", 64'(busy_w[0]), 64'd1);
    chk("t3_ack_wins_req", 64'(req_w[0]), 64'd0);

    // 4: global disable masks everything
    do_reset();
    iee = 1'b0; picsr = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_masked", 64'(req_w[0]), 64'd0);
    end
    iee = 1'b1;
    step();
    chk("t4_req", 64'(req_w[0]), 64'd1);
    chk("t4_vec", 64'(vec_w[0]), 64'd0);

    // 5: LEVEL, eoi before ack ignored, no SPR write, zero holdoff
    do_reset();
    picsr = 32'h0000_0008; iee = 1'b1;
    step();
    chk("t5_req", 64'(req_w[1]), 64'd1);
    pulse_eoi();
    chk("t5_early_eoi_ignored", 64'(req_w[1]), 64'd1);
    pulse_ack();
    pulse_eoi();
    chk("t5_no_spr", 64'(sreq_w[1]), 64'd0);
    chk("t5_holdoff_busy", 64'(busy_w[1]), 64'd1);
    picsr = 32'h0;
    step();
    chk("t5_idle_next", 64'(busy_w[1]), 64'd0);

    // 6: asynchronous reset during CLEAR
    do_reset();
    picsr = 32'h0000_0002; iee = 1'b1;
    step();
    pulse_ack();
    pulse_eoi();
    chk("t6_in_clear", 64'(sreq_w[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_sreq", 64'(sreq_w[0]), 64'd0);
    chk("t6_async_busy", 64'(busy_w[0]), 64'd0);
    chk("t6_async_dat", 64'(dat_w[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_restart_req", 64'(req_w[0]), 64'd1);
    chk("t6_restart_vec", 64'(vec_w[0]), 64'd1);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0:       picsr = 32'h0;
          1:       picsr = 32'hFFFF_FFFF;
          2:       picsr = $urandom;
          default: picsr = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        endcase
      end
      iee     = ($urandom_range(0, 15) != 0);
      ack     = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 3) == 0);
      spr_ack = ($urandom_range(0, 1) == 0);
      step();
    end
    ack = 1'b0; eoi = 1'b0; spr_ack = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
